fp_int_converter: RTL and testbench
===================================

# fp_int_converter

Multi-cycle conversion unit for the FPU datapath. It converts between the MIPS word format and IEEE-754 single precision: `cvt.s.w` (int→float) and `trunc.w.s` (float→int). It is the integer-side counterpart of the floating-point adder. It sits beside the adder and behind the same operand registers, and it uses a start/done handshake. Normalisation and denormalisation shift one bit per cycle, so the area stays small.

## Interface
- Parameters: none. Width is fixed at 32 bits (IEEE single precision / MIPS word).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  1  0 = int→float (round-to-nearest-even); 1 = float→int (truncate toward zero)
- `a`  in  32  operand; two's-complement word (op=0) or IEEE single (op=1); captured at the accepting edge
- `busy`  out  1  high from the cycle after acceptance until the result is written
- `done`  out  1  one-cycle pulse when `result` and the flags are valid
- `result`  out  32  converted value; held until the next accepted start
- `invalid`  out  1  float→int operand is NaN, infinity or out of range
- `inexact`  out  1  the result differs from the exact value

## Operation
- States are IDLE, NORM, DENORM and ROUND.
- **IDLE**
  - `start`=1 captures `a` and `op`.
  - `start` while `busy`=1 is ignored.
- **op=0 (int→float)**
  - Magnitude `m` = |a| as a 32-bit unsigned value, so 0x80000000 is kept. Sign = a[31]. `exp` = 158.
  - a=0: write result 0x00000000 and go directly to IDLE (done).
  - Otherwise go to NORM. Each cycle with m[31]=0: shift `m` left by 1 and decrement `exp`. When m[31]=1, go to ROUND.
  - ROUND:
    - frac = m[30:8], guard = m[7], sticky = |m[6:0].
    - Increment if guard & (sticky | frac[0]). A carry out of frac sets frac to 0 and increments `exp`.
    - inexact = guard | sticky. invalid = 0.
- **op=1 (float→int)**
  - e = a[30:23].
  - e=255, or e≥158 except a = 0xCF000000: result 0x7FFFFFFF, invalid=1, inexact=0. Written directly.
  - e<127 (includes zero and denormals): result 0, inexact = |a[30:0]. Written directly.
  - Otherwise: m = {1, a[22:0], 8'b0}, count = 158−e. Go to DENORM.
  - DENORM: each cycle, shift `m` right by 1 and OR the bit shifted out into sticky. Go to ROUND when count reaches 0.
  - ROUND: result = a[31] ? −m : m. inexact = sticky. invalid = 0.
- The ROUND write, and each direct write, returns to IDLE and pulses `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `invalid`=0, `inexact`=0, state = IDLE.
- Start is accepted at edge 0. `done` is high in the cycle after edge N:
  - direct writes: N = 1;
  - int→float: N = clz(|a|) + 2, maximum 33;
  - float→int: N = (158−e) + 2, maximum 33.
- `busy` is 1 in NORM, DENORM and ROUND. `busy` is 0 in the cycle `done` is high.
- Back-to-back operation: `start` in the `done` cycle is accepted.
- `rst_n` low mid-operation:
  - aborts immediately;
  - all outputs return to reset values;
  - no `done` pulse follows.
- `result`, `invalid` and `inexact` change only on a write edge.

## Structure
- Package `fp_pkg`:
  - state enum;
  - constants BIAS=127, EXP_INF=255, EXP_INT_MAX=158, INT_INVALID=32'h7FFFFFFF;
  - op encodings OP_CVT_S_W=0, OP_TRUNC_W_S=1.
- Sub-module `fp_round_rne`: combinational. Inputs are a normalised 32-bit magnitude and an 8-bit exp. Outputs are a 23-bit frac, the adjusted exp and inexact. The ROUND state of op=0 uses it.

## Test plan
- op=0, a=0x00000001 → result 0x3F800000, inexact=0, done 33 cycles after start. a=0 → 0x00000000 with done after 1 cycle.
- op=0, a=0x7FFFFFFF → 0x4F000000, inexact=1 (rounding carry into the exponent). a=0x80000000 → 0xCF000000, inexact=0. a=0x01000001 → 0x4B800000, inexact=1 (tie to even).
- op=1, a=0xC0300000 (−2.75) → 0xFFFFFFFE, inexact=1, done 32 cycles after start. a=0xCF000000 → 0x80000000, invalid=0.
- op=1: a=0x4F000000 → 0x7FFFFFFF, invalid=1. a=0x7FC00000 (NaN) → 0x7FFFFFFF, invalid=1. a=0x3F000000 (0.5) → 0, inexact=1, done after 1 cycle.
- Handshake:
  - `start` pulsed while busy → ignored, and the first result is unchanged;
  - `start` in the `done` cycle → second conversion accepted;
  - `rst_n` low during NORM → all outputs 0 and no `done`.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the integer/float conversion unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NORM   = 2'd1,
        DENORM = 2'd2,
        ROUND  = 2'd3
    } state_e;

    localparam logic [7:0]  BIAS          = 8'd127;
    localparam logic [7:0]  EXP_INF       = 8'd255;
    localparam logic [7:0]  EXP_INT_MAX   = 8'd158;
    localparam logic [31:0] INT_INVALID   = 32'h7FFF_FFFF;
    // -2^31 as a float: the only exponent-158 value that still fits a word.
    localparam logic [31:0] FLOAT_INT_MIN = 32'hCF00_0000;

    localparam logic OP_CVT_S_W   = 1'b0;
    localparam logic OP_TRUNC_W_S = 1'b1;

endpackage

// File: rtl/fp_int_converter_if.sv
// Start/done bundle between the operand registers and the conversion unit.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while busy is low; no other stall.
// Ports: start/op/a requester->unit; busy/done/result/invalid/inexact unit->requester.
interface fp_int_converter_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        invalid;
    logic        inexact;

    modport master (
        output start, op, a,
        input  busy, done, result, invalid, inexact
    );

    modport slave (
        input  start, op, a,
        output busy, done, result, invalid, inexact
    );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised 32-bit magnitude to a 23-bit fraction.
// Latency: combinational.
// Backpressure: none.
// Ports: mag/exp_in in; frac, exp_out (carry-adjusted) and inexact out.
module fp_round_rne (
    input  logic [31:0] mag,
    input  logic [7:0]  exp_in,
    output logic [22:0] frac,
    output logic [7:0]  exp_out,
    output logic        inexact
);
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;

    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    // Ties go up only when the kept fraction is odd.
    assign round_up = guard & (sticky | mag[8]);
    assign frac_sum = {1'b0, mag[30:8]} + {23'd0, round_up};

    // A carry out leaves frac_sum[22:0] at zero, which is the wanted fraction.
    assign frac     = frac_sum[22:0];
    // An unnormalised (zero) magnitude has no exponent.
    assign exp_out  = mag[31] ? (exp_in + {7'd0, frac_sum[23]}) : 8'd0;
    assign inexact  = guard | sticky;
endmodule

// File: rtl/fp_int_converter.sv
// Converts word<->single (cvt.s.w with RNE, trunc.w.s toward zero), one shift per cycle.
// Latency: 1 cycle for direct results, up to 33 cycles for shifted ones.
// Backpressure: a start while busy is dropped; result held until the next accepted start.
// Ports: clk, rst_n (async active-low), bus (fp_int_converter_if.slave).
module fp_int_converter
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fp_int_converter_if.slave bus
);
    state_e      state_q;
    state_e      state_nxt;

    logic        op_q;
    logic [31:0] a_q;
    logic [31:0] m_q;
    logic [7:0]  exp_q;
    logic [7:0]  cnt_q;
    logic        sticky_q;

    logic        load;
    logic        shift_l;
    logic        shift_r;
    logic        wr;
    logic [31:0] wr_result;
    logic        wr_invalid;
    logic        wr_inexact;

    logic [22:0] rnd_frac;
    logic [7:0]  rnd_exp;
    logic        rnd_inexact;
    logic [7:0]  a_exp;

    logic        done_q;
    logic [31:0] result_q;
    logic        invalid_q;
    logic        inexact_q;

    assign a_exp = a_q[30:23];

    fp_round_rne u_round (
        .mag     (m_q),
        .exp_in  (exp_q),
        .frac    (rnd_frac),
        .exp_out (rnd_exp),
        .inexact (rnd_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        load       = 1'b0;
        shift_l    = 1'b0;
        shift_r    = 1'b0;
        wr         = 1'b0;
        wr_result  = 32'd0;
        wr_invalid = 1'b0;
        wr_inexact = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = (bus.op == OP_CVT_S_W) ? NORM : DENORM;
                end
            end
            NORM: begin
                // A zero magnitude can only come from a=0 and never normalises.
                if (m_q == 32'd0) begin
                    wr        = 1'b1;
                    state_nxt = IDLE;
                end else if (m_q[31]) begin
                    state_nxt = ROUND;
                end else begin
                    shift_l = 1'b1;
                end
            end
            DENORM: begin
                // The operand is held constant, so the direct cases resolve on the first cycle.
                if ((a_exp == EXP_INF) || ((a_exp >= EXP_INT_MAX) && (a_q != FLOAT_INT_MIN))) begin
                    wr         = 1'b1;
                    wr_result  = INT_INVALID;
                    wr_invalid = 1'b1;
                    state_nxt  = IDLE;
                end else if (a_exp < BIAS) begin
                    wr         = 1'b1;
                    wr_inexact = |a_q[30:0];
                    state_nxt  = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_nxt = ROUND;
                end else begin
                    shift_r = 1'b1;
                end
            end
            ROUND: begin
                wr        = 1'b1;
                state_nxt = IDLE;
                if (op_q == OP_CVT_S_W) begin
                    wr_result  = {a_q[31], rnd_exp, rnd_frac};
                    wr_inexact = rnd_inexact;
                end else begin
                    wr_result  = a_q[31] ? (~m_q + 32'd1) : m_q;
                    wr_inexact = sticky_q;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_CVT_S_W;
            a_q      <= 32'd0;
            m_q      <= 32'd0;
            exp_q    <= 8'd0;
            cnt_q    <= 8'd0;
            sticky_q <= 1'b0;
        end else if (load) begin
            op_q     <= bus.op;
            a_q      <= bus.a;
            sticky_q <= 1'b0;
            exp_q    <= EXP_INT_MAX;
            if (bus.op == OP_CVT_S_W) begin
                // Two's-complement negate keeps 0x80000000 as the 2^31 magnitude.
                m_q   <= bus.a[31] ? (~bus.a + 32'd1) : bus.a;
                cnt_q <= 8'd0;
            end else begin
                // Hidden bit lands at bit 31, i.e. value * 2^(158-e) in integer units.
                m_q   <= {1'b1, bus.a[22:0], 8'd0};
                cnt_q <= EXP_INT_MAX - bus.a[30:23];
            end
        end else if (shift_l) begin
            m_q   <= {m_q[30:0], 1'b0};
            exp_q <= exp_q - 8'd1;
        end else if (shift_r) begin
            m_q      <= {1'b0, m_q[31:1]};
            sticky_q <= sticky_q | m_q[0];
            cnt_q    <= cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            result_q  <= 32'd0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            done_q <= wr;
            if (wr) begin
                result_q  <= wr_result;
                invalid_q <= wr_invalid;
                inexact_q <= wr_inexact;
            end
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.invalid = invalid_q;
    assign bus.inexact = inexact_q;
endmodule

// File: tb/tb_fp_int_converter.sv
// Directed vector bench for fp_int_converter plus handshake/reset sequences.
// Latency: measured per vector in cycles from the accepting edge to done.
// Backpressure: exercises start-while-busy and start-in-done-cycle.
module tb_fp_int_converter;
    logic clk = 1'b0;
    logic rst_n;

    fp_int_converter_if bus ();

    fp_int_converter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    int extra_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; start is seen by the next edge (edge 0).
    task automatic launch(input logic op, input logic [31:0] a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns N such that done is high after edge N (40 means it never came).
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.done && cycles < 40);
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 32'd0;
        rst_n     = 1'b0;

        vecs[0]  = '{1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 33};
        vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[2]  = '{1'b0, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b0, 1'b1, 3};
        vecs[3]  = '{1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0, 2};
        vecs[4]  = '{1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b0, 1'b1, 9};
        vecs[5]  = '{1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b0, 1'b1, 9};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0, 33};
        vecs[7]  = '{1'b0, 32'h0000_0003, 32'h4040_0000, 1'b0, 1'b0, 32};
        vecs[8]  = '{1'b1, 32'hC030_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 32};
        vecs[9]  = '{1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2};
        vecs[10] = '{1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        vecs[11] = '{1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        vecs[12] = '{1'b1, 32'hFF80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        vecs[13] = '{1'b1, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1};
        vecs[14] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[15] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[16] = '{1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 33};
        vecs[17] = '{1'b1, 32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 10};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy",    {31'd0, bus.busy},    32'd0);
        check("reset done",    {31'd0, bus.done},    32'd0);
        check("reset result",  bus.result,           32'd0);
        check("reset invalid", {31'd0, bus.invalid}, 32'd0);
        check("reset inexact", {31'd0, bus.inexact}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].op, vecs[i].a);
            wait_done(n);
            check($sformatf("v%0d latency", i), n,                     vecs[i].lat);
            check($sformatf("v%0d result", i),  bus.result,            vecs[i].res);
            check($sformatf("v%0d invalid", i), {31'd0, bus.invalid},  {31'd0, vecs[i].inv});
            check($sformatf("v%0d inexact", i), {31'd0, bus.inexact},  {31'd0, vecs[i].inx});
            check($sformatf("v%0d busy@done", i), {31'd0, bus.busy},   32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse", i), {31'd0, bus.done},  32'd0);
        end

        // Start while busy must be dropped.
        launch(1'b0, 32'h0000_0001);
        repeat (4) @(posedge clk);
        #1;
        check("ignore busy high", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'h3F80_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n);
        check("ignore latency", 5 + n,      33);
        check("ignore result",  bus.result, 32'h3F80_0000);
        count_done(40, extra_done);
        check("ignore no 2nd done", extra_done, 0);
        check("ignore result held", bus.result, 32'h3F80_0000);

        // Start in the done cycle is accepted.
        launch(1'b0, 32'h8000_0000);
        wait_done(n);
        check("b2b first latency", n,          2);
        check("b2b first result",  bus.result, 32'hCF00_0000);
        launch(1'b1, 32'hC030_0000);
        wait_done(n);
        check("b2b second latency", n,                    32);
        check("b2b second result",  bus.result,           32'hFFFF_FFFE);
        check("b2b second inexact", {31'd0, bus.inexact}, 32'd1);

        // Reset during NORM aborts with no done.
        launch(1'b0, 32'h0000_0001);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy",    {31'd0, bus.busy},    32'd0);
        check("abort done",    {31'd0, bus.done},    32'd0);
        check("abort result",  bus.result,           32'd0);
        check("abort invalid", {31'd0, bus.invalid}, 32'd0);
        check("abort inexact", {31'd0, bus.inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, extra_done);
        check("abort no done",   extra_done,         0);
        check("abort idle busy", {31'd0, bus.busy},  32'd0);
        check("abort result 0",  bus.result,         32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
